slice_reg_array: RTL

Behavioural model of an array of LIFCL SLICE register pairs (Q0/Q1), each slice with its own runtime-loaded register configuration: REGSET, SEL, LSRMODE, GSR and SRMODE. Configuration arrives as one byte per slice over a valid/ready stream. The model then runs cycle-accurate register behaviour that the register-config fuzzing results are checked against. It is a parametrised, multi-slice generalisation of single-slice register configuration, and adds PRLD preload, the async-LSR output override and config sequencing.

---
 rtl/slice_reg_pkg.sv | 37 +++
 rtl/slice_reg_cell.sv | 51 +++++
 rtl/slice_reg_array.sv | 83 ++++++++
 3 files changed

// File: rtl/slice_reg_pkg.sv
// Shared types for the slice register array: the per-slice config byte layout,
// the register-mode enums and the config loader states.
package slice_reg_pkg;

    localparam int CFG_W       = 8;
    localparam int REG_FIELD_W = 3;
    localparam int BIT_REGSET0 = 0;
    localparam int BIT_SEL0    = 1;
    localparam int BIT_LSRMOD0 = 2;
    localparam int BIT_REGSET1 = 3;
    localparam int BIT_SEL1    = 4;
    localparam int BIT_LSRMOD1 = 5;
    localparam int BIT_GSR     = 6;
    localparam int BIT_SRMODE  = 7;

    typedef enum logic {REGSET_RESET = 1'b0, REGSET_SET   = 1'b1} regset_e;
    typedef enum logic {SEL_DL       = 1'b0, SEL_DF       = 1'b1} sel_e;
    typedef enum logic {LSRMODE_LSR  = 1'b0, LSRMODE_PRLD = 1'b1} lsrmode_e;
    typedef enum logic {SRMODE_LSR_OVER_CE = 1'b0, SRMODE_ASYNC = 1'b1} srmode_e;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2} state_e;

    // One register's 3-bit field; MSB-first so it lines up with the byte layout.
    typedef struct packed {
        lsrmode_e lsrmode;
        sel_e     sel;
        regset_e  regset;
    } reg_cfg_t;

    typedef struct packed {
        srmode_e  srmode;
        logic     gsr_en;
        reg_cfg_t reg1;
        reg_cfg_t reg0;
    } slice_cfg_t;

endpackage

// File: rtl/slice_reg_cell.sv
// One SLICE register pair (Q0/Q1) with GSR, LSR/PRLD, clock enable and the
// optional combinational ASYNC LSR override on the outputs.
module slice_reg_cell
    import slice_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  slice_cfg_t cfg,
    input  logic       run,
    input  logic       gsr,
    input  logic       ce,
    input  logic       lsr,
    input  logic [1:0] dl,
    input  logic [1:0] df,
    input  logic [1:0] m,
    output logic [1:0] q
);

    reg_cfg_t [1:0] rc;
    logic [1:0]     init;
    logic [1:0]     lsr_tgt;
    logic [1:0]     d_sel;
    logic [1:0]     q_reg;

    assign rc = {cfg.reg1, cfg.reg0};

    always_comb begin
        init    = '0;
        lsr_tgt = '0;
        d_sel   = '0;
        for (int k = 0; k < 2; k++) begin
            init[k]    = (rc[k].regset == REGSET_SET);
            lsr_tgt[k] = (rc[k].lsrmode == LSRMODE_PRLD) ? m[k] : init[k];
            d_sel[k]   = (rc[k].sel == SEL_DF) ? df[k] : dl[k];
        end
    end

    // While not running, track the init value so the edge entering RUN lands on it.
    always_ff @(posedge clk) begin
        if (rst)                     q_reg <= '0;
        else if (!run)               q_reg <= init;
        else if (gsr && cfg.gsr_en)  q_reg <= init;
        else if (lsr)                q_reg <= lsr_tgt;
        else if (ce)                 q_reg <= d_sel;
    end

    assign q = !run ? 2'b00
             : (cfg.srmode == SRMODE_ASYNC && lsr) ? lsr_tgt
             : q_reg;

endmodule

// File: rtl/slice_reg_array.sv
// Array of SLICE register pairs: a byte-per-slice config loader followed by
// cycle-accurate register behaviour once every slice is configured.
module slice_reg_array
    import slice_reg_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    input  logic [CFG_W-1:0]        cfg_data,
    output logic                    cfg_ready,
    output logic                    cfg_done,
    input  logic                    gsr,
    input  logic [NUM_SLICES-1:0]   ce,
    input  logic [NUM_SLICES-1:0]   lsr,
    input  logic [2*NUM_SLICES-1:0] dl,
    input  logic [2*NUM_SLICES-1:0] df,
    input  logic [2*NUM_SLICES-1:0] m,
    output logic [2*NUM_SLICES-1:0] q
);

    localparam int CW = $clog2(NUM_SLICES + 1);

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q;
    slice_cfg_t [NUM_SLICES-1:0]  cfg_q, cfg_d;
    logic                         accept;
    logic                         last;
    logic                         run;

    assign cfg_ready = (state_q != ST_RUN);
    assign cfg_done  = (state_q == ST_RUN);
    assign run       = (state_q == ST_RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign last      = (cnt_q == CW'(NUM_SLICES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = last ? ST_RUN : ST_LOAD;
            ST_LOAD: if (accept && last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_d = cfg_q;
        for (int i = 0; i < NUM_SLICES; i++)
            if (accept && cnt_q == CW'(i)) cfg_d[i] = slice_cfg_t'(cfg_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            if (accept) cnt_q <= cnt_q + CW'(1);
        end
    end

    // Cells see the post-write config so the last byte's init is ready at the RUN edge.
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        slice_reg_cell u_cell (
            .clk (clk),
            .rst (rst),
            .cfg (cfg_d[s]),
            .run (run),
            .gsr (gsr),
            .ce  (ce[s]),
            .lsr (lsr[s]),
            .dl  (dl[2*s +: 2]),
            .df  (df[2*s +: 2]),
            .m   (m[2*s +: 2]),
            .q   (q[2*s +: 2])
        );
    end

endmodule
